// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: FSM encoding and requester count.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int NUM_REQ = 2;

endpackage

// File: rtl/alu.sv
// Shared ALU datapath. status = {V, C, N, Z}; C and V are only meaningful for FS 0..3.
module alu #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       FS,
   input  logic             C0,
   output logic [WIDTH-1:0] F,
   output logic [3:0]       status
);

   logic [WIDTH-1:0] y;
   logic [WIDTH:0]   sum;
   logic             arith;

   always_comb begin
      arith = (FS[4:2] == 3'b000);
      // FS 0..3 share one adder: A + {0, B, ~B, -1} + C0
      case (FS[1:0])
         2'd0:    y = '0;
         2'd1:    y = B;
         2'd2:    y = ~B;
         default: y = '1;
      endcase
      sum = {1'b0, A} + {1'b0, y} + {{WIDTH{1'b0}}, C0};
      case (FS)
         5'd0, 5'd1, 5'd2, 5'd3: F = sum[WIDTH-1:0];
         5'd4:    F = A & B;
         5'd5:    F = A | B;
         5'd6:    F = A ^ B;
         5'd7:    F = ~A;
         5'd8:    F = B;
         5'd9:    F = B >> 1;
         5'd10:   F = B << 1;
         default: F = '0;
      endcase
      status[3] = arith & (A[WIDTH-1] == y[WIDTH-1]) & (F[WIDTH-1] != A[WIDTH-1]);
      status[2] = arith & sum[WIDTH];
      status[1] = F[WIDTH-1];
      status[0] = (F == '0);
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: ptr names the preferred requester when both request.
module rr_arb2
   import alu_ctrl_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               ptr,
   output logic [NUM_REQ-1:0] grant
);

   always_comb begin
      if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else              grant = req;
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: accept, execute, then hold the result
// until the owning requester takes it.
module alu_req_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   input  logic [WIDTH-1:0]   req0_A,
   input  logic [WIDTH-1:0]   req0_B,
   input  logic [WIDTH-1:0]   req1_A,
   input  logic [WIDTH-1:0]   req1_B,
   input  logic [4:0]         req0_FS,
   input  logic [4:0]         req1_FS,
   input  logic               req0_C0,
   input  logic               req1_C0,
   output logic [NUM_REQ-1:0] rsp_valid,
   input  logic [NUM_REQ-1:0] rsp_ready,
   output logic [WIDTH-1:0]   rsp_F,
   output logic [3:0]         rsp_status
);

   state_e             state_q, state_d;
   logic               ptr_q, ptr_d;
   logic               owner_q, owner_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [4:0]         fs_q, fs_d;
   logic               c0_q, c0_d;
   logic [WIDTH-1:0]   f_q, f_d;
   logic [3:0]         status_q, status_d;
   logic [NUM_REQ-1:0] grant;
   logic [WIDTH-1:0]   alu_f;
   logic [3:0]         alu_status;

   rr_arb2 u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   alu #(.WIDTH(WIDTH)) u_alu (
      .A      (a_q),
      .B      (b_q),
      .FS     (fs_q),
      .C0     (c0_q),
      .F      (alu_f),
      .status (alu_status)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      a_d       = a_q;
      b_d       = b_q;
      fs_d      = fs_q;
      c0_d      = c0_q;
      f_d       = f_q;
      status_d  = status_q;
      req_ready = '0;
      rsp_valid = '0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready = grant;
               owner_d   = grant[1];
               // Prefer the requester that lost (or did not ask) this time.
               ptr_d     = grant[0];
               a_d       = grant[1] ? req1_A  : req0_A;
               b_d       = grant[1] ? req1_B  : req0_B;
               fs_d      = grant[1] ? req1_FS : req0_FS;
               c0_d      = grant[1] ? req1_C0 : req0_C0;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            f_d      = alu_f;
            status_d = alu_status;
            state_d  = RESP;
         end
         RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (reset) begin
         req_ready = '0;
         rsp_valid = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         owner_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         fs_q     <= '0;
         c0_q     <= 1'b0;
         f_q      <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         a_q      <= a_d;
         b_q      <= b_d;
         fs_q     <= fs_d;
         c0_q     <= c0_d;
         f_q      <= f_d;
         status_q <= status_d;
      end
   end

   assign rsp_F      = f_q;
   assign rsp_status = status_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: FS sweep, contention, backpressure, reset and operand churn.
module tb_alu_req_arbiter;

   localparam int W = 64;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic         reset;
   logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [W-1:0] req0_A, req0_B, req1_A, req1_B, rsp_F;
   logic [4:0]   req0_FS, req1_FS;
   logic         req0_C0, req1_C0;
   logic [3:0]   rsp_status;

   logic [W-1:0] ref_A, ref_B, ref_F;
   logic [4:0]   ref_FS;
   logic         ref_C0;
   logic [3:0]   ref_status;

   int n_chk = 0;
   int n_err = 0;

   alu_req_arbiter #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_A     (req0_A),
      .req0_B     (req0_B),
      .req1_A     (req1_A),
      .req1_B     (req1_B),
      .req0_FS    (req0_FS),
      .req1_FS    (req1_FS),
      .req0_C0    (req0_C0),
      .req1_C0    (req1_C0),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_F      (rsp_F),
      .rsp_status (rsp_status)
   );

   alu #(.WIDTH(W)) u_ref (
      .A      (ref_A),
      .B      (ref_B),
      .FS     (ref_FS),
      .C0     (ref_C0),
      .F      (ref_F),
      .status (ref_status)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; checks follow a further settle.
   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      req0_A = '0; req0_B = '0; req0_FS = '0; req0_C0 = 1'b0;
      req1_A = '0; req1_B = '0; req1_FS = '0; req1_C0 = 1'b0;
      ref_A  = '0; ref_B  = '0; ref_FS  = '0; ref_C0  = 1'b0;

      cyc();
      cyc();
      settle();
      check("rst_req_ready", W'(req_ready), 0);
      check("rst_rsp_valid", W'(rsp_valid), 0);
      check("rst_rsp_F", rsp_F, 0);
      check("rst_rsp_status", W'(rsp_status), 0);
      reset     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      cyc();

      // Single requester, full FS sweep with both carry-in values.
      for (int c = 0; c < 2; c++) begin
         for (int f = 0; f < 32; f++) begin
            req0_A = 205; req0_B = 512; req0_FS = 5'(f); req0_C0 = 1'(c);
            ref_A  = 205; ref_B  = 512; ref_FS  = 5'(f); ref_C0  = 1'(c);
            req_valid = 2'b01;
            settle();
            check("sw_accept", W'(req_ready), 1);
            cyc();
            req_valid = 2'b00;
            settle();
            check("sw_exec_quiet", W'(rsp_valid), 0);
            cyc();
            rsp_ready = 2'b01;
            settle();
            check("sw_rsp_valid", W'(rsp_valid), 1);
            check("sw_F", rsp_F, ref_F);
            check("sw_status", W'(rsp_status), W'(ref_status));
            if (f == 1 && c == 0) begin
               check("add_F", rsp_F, 717);
               check("add_status", W'(rsp_status), 0);
            end
            if (f == 2 && c == 1) begin
               check("sub_F", rsp_F, 64'hFFFF_FFFF_FFFF_FECD);
               check("sub_status", W'(rsp_status), 2);
            end
            if (f == 4 && c == 0) begin
               check("and_F", rsp_F, 0);
               check("and_status", W'(rsp_status), 1);
            end
            cyc();
            rsp_ready = 2'b00;
         end
      end

      // Pointer was left at requester 1; reset must return it to requester 0.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      req0_A = 100;  req0_B = 1;  req0_FS = 5'd1; req0_C0 = 1'b0;
      req1_A = 1000; req1_B = 24; req1_FS = 5'd1; req1_C0 = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int g = 0; g < 4; g++) begin
         settle();
         check("ct_grant", W'(req_ready), (g % 2 == 0) ? 1 : 2);
         cyc();
         settle();
         check("ct_exec_quiet", W'(rsp_valid), 0);
         cyc();
         settle();
         check("ct_rsp_valid", W'(rsp_valid), (g % 2 == 0) ? 1 : 2);
         check("ct_F", rsp_F, (g % 2 == 0) ? 101 : 1024);
         cyc();
      end

      // Backpressure on requester 0 while requester 1 waits.
      req0_A = 7; req0_B = 8; req0_FS = 5'd1;
      req1_A = 3; req1_B = 4; req1_FS = 5'd1;
      req_valid = 2'b01;
      rsp_ready = 2'b00;
      settle();
      check("bp_accept", W'(req_ready), 1);
      cyc();
      req_valid = 2'b10;
      cyc();
      for (int k = 0; k < 10; k++) begin
         settle();
         check("bp_rsp_valid", W'(rsp_valid), 1);
         check("bp_F", rsp_F, 15);
         check("bp_status", W'(rsp_status), 0);
         check("bp_req_ready", W'(req_ready), 0);
         cyc();
      end
      rsp_ready = 2'b01;
      settle();
      check("bp_release_valid", W'(rsp_valid), 1);
      cyc();
      rsp_ready = 2'b00;
      settle();
      check("bp_done", W'(rsp_valid), 0);
      check("bp_waiter_granted", W'(req_ready), 2);

      // Requester 1 owns the result; ready from requester 0 must not complete it.
      cyc();
      req_valid = 2'b00;
      cyc();
      rsp_ready = 2'b01;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("wo_rsp_valid", W'(rsp_valid), 2);
         check("wo_F", rsp_F, 7);
         cyc();
      end
      rsp_ready = 2'b10;
      settle();
      check("wo_owner_valid", W'(rsp_valid), 2);
      cyc();
      rsp_ready = 2'b00;
      settle();
      check("wo_done", W'(rsp_valid), 0);

      // Reset while executing a req0 operation (pointer now at requester 1).
      req0_A = 9; req0_B = 9; req0_FS = 5'd1;
      req_valid = 2'b01;
      settle();
      check("ra_accept", W'(req_ready), 1);
      cyc();
      req_valid = 2'b00;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      settle();
      check("ra_rsp_valid", W'(rsp_valid), 0);
      check("ra_rsp_F", rsp_F, 0);
      check("ra_rsp_status", W'(rsp_status), 0);
      check("ra_req_ready", W'(req_ready), 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         settle();
         check("ra_no_stale", W'(rsp_valid), 0);
      end

      // Both valid after reset: requester 0 wins; its A changes right after accept.
      req0_A = 205; req0_B = 512; req0_FS = 5'd1; req0_C0 = 1'b0;
      req1_A = 1;   req1_B = 1;   req1_FS = 5'd1;
      req_valid = 2'b11;
      settle();
      check("ra_ptr_reset", W'(req_ready), 1);
      cyc();
      req0_A = 0;
      req_valid = 2'b00;
      cyc();
      settle();
      check("churn_valid", W'(rsp_valid), 1);
      check("churn_F", rsp_F, 717);
      check("churn_status", W'(rsp_status), 0);
      rsp_ready = 2'b01;
      cyc();
      rsp_ready = 2'b00;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
